// File: rtl/rv_data_memory.sv
// rtl/rv_data_memory.sv - RV32I byte-addressed data memory with valid/ready request/response
module rv_data_memory #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // One extra bit so the range check never wraps when memory fills the whole address space.
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]       size;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             illegal;
    logic             misaligned;
    logic             out_of_range;
    logic             req_err;
    logic             accept;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [3:0]       wstrb;
    logic [31:0]      wdata_rep;

    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        size         = req_funct3[1:0];
        lane         = req_addr[1:0];
        idx          = req_addr[2 +: IDX_W];
        illegal      = req_we ? (req_funct3[2] || size == 2'b11)
                              : (size == 2'b11 || (req_funct3[2] && req_funct3[1]));
        misaligned   = (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
        out_of_range = {1'b0, req_addr} >= MEM_BYTES;
        req_err      = illegal || misaligned || out_of_range;

        rd_word = mem[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = rd_word;
        wstrb     = 4'b1111;
        wdata_rep = req_wdata;
        case (size)
            2'b00: begin
                load_data = {{24{~req_funct3[2] & rd_byte[7]}}, rd_byte};
                wdata_rep = {4{req_wdata[7:0]}};
                case (lane)
                    2'b00:   wstrb = 4'b0001;
                    2'b01:   wstrb = 4'b0010;
                    2'b10:   wstrb = 4'b0100;
                    default: wstrb = 4'b1000;
                endcase
            end
            2'b01: begin
                load_data = {{16{~req_funct3[2] & rd_half[15]}}, rd_half};
                wdata_rep = {2{req_wdata[15:0]}};
                wstrb     = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Storage is not reset, but writes are still blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && accept && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= req_err;
            resp_rdata <= (req_err || req_we) ? 32'd0 : load_data;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_data_memory.sv
// tb/tb_rv_data_memory.sv - randomized self-checking bench for rv_data_memory against a byte-array model
module tb_rv_data_memory;

    localparam int DEPTH     = 1024;
    localparam int MEM_BYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [MEM_BYTES];

    rv_data_memory #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Reference: byte-addressed little-endian array, rules taken straight from the ISA.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int     n;
        longint v;
        e  = 1'b0;
        rd = 32'd0;
        case (f3[1:0])
            2'd0:    n = 1;
            2'd1:    n = 2;
            2'd2:    n = 4;
            default: n = 0;
        endcase
        if (n == 0) e = 1'b1;
        if (we && f3[2]) e = 1'b1;
        if (!we && f3[2] && n == 4) e = 1'b1;
        if (n != 0 && (addr % n) != 0) e = 1'b1;
        if (addr >= 32'(MEM_BYTES)) e = 1'b1;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
                if (!f3[2] && v[8*n-1]) v = v - (longint'(1) << (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got_rd, output logic got_err);
        logic        e;
        logic [31:0] rd;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        model(we, f3, addr, wd, e, rd);
        got_rd  = resp_rdata;
        got_err = resp_err;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_valid we=%0b f3=%0d addr=%h: got %b want 1", we, f3, addr, resp_valid);
        end
        checks++;
        if (resp_err !== e) begin
            errors++;
            $display("FAIL resp_err we=%0b f3=%0d addr=%h: got %b want %b", we, f3, addr, resp_err, e);
        end
        checks++;
        if (resp_rdata !== rd) begin
            errors++;
            $display("FAIL resp_rdata we=%0b f3=%0d addr=%h: got %h want %h", we, f3, addr, resp_rdata, rd);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp_valid: got %b want 0", resp_valid);
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b e=%b d=%h rdy=%b want 0 0 0 1",
                     resp_valid, resp_err, resp_rdata, req_ready);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic init_mem();
        logic [31:0] d;
        logic        e;
        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, d, e);
        idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        e;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        expect_val("stall_valid", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_val("async_rst_valid", {31'd0, resp_valid}, 32'd0);
        expect_val("async_rst_ready", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h0;
        req_wdata  = ~{ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_val("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        do_req(1'b0, 3'b010, 32'h0, 32'd0, d, e);
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        e;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, d, e);
        expect_val("b2b_lw", d, 32'hDEADBEEF);
        idle();
    endtask

    task automatic test_lanes();
        logic [31:0] d;
        logic        e;
        do_req(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, d, e);
        do_req(1'b1, 3'b001, 32'h12, 32'hABCD1234, d, e);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, d, e);
        expect_val("lanes_lw", d, 32'h123455EF);
        do_req(1'b0, 3'b000, 32'h13, 32'd0, d, e);
        expect_val("lanes_lb13", d, 32'h00000012);
        do_req(1'b0, 3'b100, 32'h10, 32'd0, d, e);
        expect_val("lanes_lbu10", d, 32'h000000EF);
        do_req(1'b0, 3'b000, 32'h10, 32'd0, d, e);
        expect_val("lanes_lb10", d, 32'hFFFFFFEF);
        do_req(1'b0, 3'b001, 32'h10, 32'd0, d, e);
        expect_val("lanes_lh10", d, 32'h000055EF);
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        do_req(1'b0, 3'b010, 32'h12, 32'd0, d, e);
        expect_val("err_lw_misaligned", {31'd0, e}, 32'd1);
        do_req(1'b1, 3'b001, 32'h11, 32'h7777, d, e);
        expect_val("err_sh_misaligned", {31'd0, e}, 32'd1);
        do_req(1'b0, 3'b011, 32'h10, 32'd0, d, e);
        expect_val("err_funct3_011", {31'd0, e}, 32'd1);
        do_req(1'b0, 3'b010, 32'(MEM_BYTES), 32'd0, d, e);
        expect_val("err_lw_oor", {31'd0, e}, 32'd1);
        do_req(1'b1, 3'b000, 32'hFFFFFFFF, 32'h99, d, e);
        expect_val("err_sb_top", {31'd0, e}, 32'd1);
        do_req(1'b1, 3'b100, 32'h10, 32'h99, d, e);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, d, e);
        expect_val("err_mem_unchanged", d, 32'h123455EF);
        idle();
    endtask

    task automatic test_backpressure();
        logic [31:0] a0, a1, a2;
        logic        e;
        logic [31:0] held;
        a0 = 32'h40; a1 = 32'h44; a2 = 32'h46;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = a0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        model(1'b0, 3'b010, a0, 32'd0, e, held);
        req_funct3 = 3'b001;
        req_addr   = a1;
        for (int c = 0; c < 4; c++) begin
            expect_val("bp_ready", {31'd0, req_ready}, 32'd0);
            expect_val("bp_valid", {31'd0, resp_valid}, 32'd1);
            expect_val("bp_rdata_stable", resp_rdata, held);
            expect_val("bp_err_stable", {31'd0, resp_err}, 32'd0);
            @(posedge clk);
            #1;
        end
        do_req(1'b0, 3'b001, a1, 32'd0, held, e);
        do_req(1'b0, 3'b101, a2, 32'd0, held, e);
        idle();
    endtask

    task automatic test_last_word();
        logic [31:0] d;
        logic        e;
        logic [31:0] w0;
        w0 = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
        do_req(1'b1, 3'b010, 32'(MEM_BYTES - 4), 32'hA5A5A5A5, d, e);
        do_req(1'b0, 3'b101, 32'(MEM_BYTES - 2), 32'd0, d, e);
        expect_val("last_lhu", d, 32'h0000A5A5);
        expect_val("last_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 3'b010, 32'h0, 32'd0, d, e);
        expect_val("last_word0", d, w0);
        idle();
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        e;
        logic [31:0] addr;
        int          sel;
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       addr = $urandom_range(0, MEM_BYTES - 1);
            else if (sel == 8) addr = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 8);
            else               addr = $urandom;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, d, e);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
    endtask

    task automatic test_sweep();
        logic [31:0] d;
        logic        e;
        for (int w = 0; w < DEPTH; w++) do_req(1'b0, 3'b010, 32'(w * 4), 32'd0, d, e);
        idle();
    endtask

    initial begin
        test_reset();
        init_mem();
        test_async_reset();
        test_back_to_back();
        test_lanes();
        test_errors();
        test_backpressure();
        test_last_word();
        test_random();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
